// File: rtl/inst_queue_pkg.sv
// Shared definitions for the dual-issue instruction queue.
// Holds the NOP encoding, the control-bus width, the entry layout and the
// default queue depth, plus helpers that build or blank an entry.
`ifndef CTRL_BUS
`define CTRL_BUS 16
`endif

package inst_queue_pkg;

    localparam int          CTRL_W   = `CTRL_BUS;
    localparam int          IQ_DEPTH = 8;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One queued instruction: word, decoded control, prediction and PC
    typedef struct packed {
        logic [31:0]       inst;
        logic [CTRL_W-1:0] ctrl;
        logic              pred;
        logic [31:0]       pred_tgt;
        logic [31:0]       pc;
    } iq_entry_t;

    localparam int ENTRY_W = 32 + CTRL_W + 1 + 32 + 32;

    // Bubble shown on an empty slot: ADDI x0,x0,0 with all control cleared,
    // so issue sees no register write and no dependency.
    function automatic iq_entry_t nop_entry();
        iq_entry_t e;
        e.inst     = NOP_INST;
        e.ctrl     = {CTRL_W{1'b0}};
        e.pred     = 1'b0;
        e.pred_tgt = 32'h0000_0000;
        e.pc       = 32'h0000_0000;
        return e;
    endfunction

    function automatic iq_entry_t make_entry(
        input logic [31:0]       inst,
        input logic [CTRL_W-1:0] ctrl,
        input logic              pred,
        input logic [31:0]       pred_tgt,
        input logic [31:0]       pc
    );
        iq_entry_t e;
        e.inst     = inst;
        e.ctrl     = ctrl;
        e.pred     = pred;
        e.pred_tgt = pred_tgt;
        e.pc       = pc;
        return e;
    endfunction

endpackage

// File: rtl/inst_queue_chk.sv
// Protocol checker for the decode side of the instruction queue.
// Ports: clock_i, reset_i, in_valid0_i, in_valid1_i.
// Decode must never present slot 1 without slot 0.
module inst_queue_chk (
    input logic clock_i,
    input logic reset_i,
    input logic in_valid0_i,
    input logic in_valid1_i
);

    slot1_needs_slot0_a: assert property (
        @(posedge clock_i) disable iff (reset_i) in_valid1_i |-> in_valid0_i
    );

endmodule

// File: rtl/inst_queue_entry_mem.sv
// iq_entry_mem: DEPTH x entry storage for the instruction queue.
// Ports: clock_i/reset_i; two write ports (wr_en*, wr_addr*, wr_data*) used
// for tail and tail+1; two combinational read ports (rd_addr*, rd_data*)
// used for head and head+1.
module iq_entry_mem
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             wr_en0,
    input  logic [PTR_W-1:0] wr_addr0,
    input  iq_entry_t        wr_data0,
    input  logic             wr_en1,
    input  logic [PTR_W-1:0] wr_addr1,
    input  iq_entry_t        wr_data1,
    input  logic [PTR_W-1:0] rd_addr0,
    output iq_entry_t        rd_data0,
    input  logic [PTR_W-1:0] rd_addr1,
    output iq_entry_t        rd_data1
);

    iq_entry_t mem_r [DEPTH];

    // Entry storage; the two write addresses are always distinct (tail, tail+1)
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en0) begin
                mem_r[wr_addr0] <= wr_data0;
            end
            if (wr_en1) begin
                mem_r[wr_addr1] <= wr_data1;
            end
        end
    end

    assign rd_data0 = mem_r[rd_addr0];
    assign rd_data1 = mem_r[rd_addr1];

endmodule

// File: rtl/inst_queue.sv
// inst_queue: two-in / two-out instruction queue between decode and issue.
// Ports: clock_i, reset_i (async, active high), flush_i; decode pair
// in_valid*/in_inst*/in_ctrl*/in_pred*/in_pred_tgt*/in_pc* with in_ready_o;
// issue feedback stall_i, issue0_special_stall_i, issue1_special_stall_i;
// issue pair out_valid*/inst*/ctrl*/pred_*/pred_tgt_*/pc_*; count_o.
// Optional build macro IQ_BYPASS_EN: an empty queue forwards the incoming
// pair straight to the outputs in the same cycle and only stores what issue
// does not consume.
`ifndef CTRL_BUS
`define CTRL_BUS 16
`endif

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 in_valid0_i,
    input  logic                 in_valid1_i,
    input  logic [31:0]          in_inst0_i,
    input  logic [31:0]          in_inst1_i,
    input  logic [`CTRL_BUS-1:0] in_ctrl0_i,
    input  logic [`CTRL_BUS-1:0] in_ctrl1_i,
    input  logic                 in_pred0_i,
    input  logic                 in_pred1_i,
    input  logic [31:0]          in_pred_tgt0_i,
    input  logic [31:0]          in_pred_tgt1_i,
    input  logic [31:0]          in_pc0_i,
    input  logic [31:0]          in_pc1_i,
    output logic                 in_ready_o,
    input  logic                 stall_i,
    input  logic                 issue0_special_stall_i,
    input  logic                 issue1_special_stall_i,
    output logic                 out_valid0_o,
    output logic                 out_valid1_o,
    output logic [31:0]          inst0_o,
    output logic [31:0]          inst1_o,
    output logic [`CTRL_BUS-1:0] ctrl0_o,
    output logic [`CTRL_BUS-1:0] ctrl1_o,
    output logic                 pred_0_o,
    output logic                 pred_1_o,
    output logic [31:0]          pred_tgt_0_o,
    output logic [31:0]          pred_tgt_1_o,
    output logic [31:0]          pc_0_o,
    output logic [31:0]          pc_1_o,
    output logic [PTR_W:0]       count_o
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);

    logic [PTR_W-1:0] head_r, tail_r;
    logic [PTR_W:0]   count_r;

    iq_entry_t        in_e0_s, in_e1_s, push0_s, wr_data0_s;
    iq_entry_t        rd0_s, rd1_s, view0_s, view1_s, out0_s, out1_s;
    logic [1:0]       npush_s, npop_s, nwr_s, nhead_s;
    logic [PTR_W:0]   avail_s;
    logic             ready_s, byp_s, vld0_s, vld1_s;

    assign ready_s = (DEPTH_C - count_r) >= CNT_TWO;

`ifdef IQ_BYPASS_EN
    assign byp_s = (count_r == {(PTR_W+1){1'b0}}) && !flush_i;
`else
    assign byp_s = 1'b0;
`endif

    // Pack the decode pair; a lone slot-1 valid is demoted to a slot-0 push
    always_comb begin
        in_e0_s = make_entry(in_inst0_i, in_ctrl0_i, in_pred0_i, in_pred_tgt0_i, in_pc0_i);
        in_e1_s = make_entry(in_inst1_i, in_ctrl1_i, in_pred1_i, in_pred_tgt1_i, in_pc1_i);
        if (in_valid0_i) begin
            push0_s = in_e0_s;
            npush_s = in_valid1_i ? 2'd2 : 2'd1;
        end else if (in_valid1_i) begin
            push0_s = in_e1_s;
            npush_s = 2'd1;
        end else begin
            push0_s = in_e0_s;
            npush_s = 2'd0;
        end
    end

    // Retire count from issue feedback, bounded by what is actually visible
    always_comb begin
        avail_s = byp_s ? (PTR_W+1)'(npush_s) : count_r;
        if (stall_i || issue0_special_stall_i) begin
            npop_s = 2'd0;
        end else if (issue1_special_stall_i) begin
            npop_s = (avail_s >= CNT_ONE) ? 2'd1 : 2'd0;
        end else if (avail_s >= CNT_TWO) begin
            npop_s = 2'd2;
        end else if (avail_s == CNT_ONE) begin
            npop_s = 2'd1;
        end else begin
            npop_s = 2'd0;
        end
    end

    // Bypassed pops consume incoming instructions, not stored ones, so only
    // the leftovers are written and head does not move.
    always_comb begin
        if (byp_s) begin
            nwr_s   = npush_s - npop_s;
            nhead_s = 2'd0;
        end else if (ready_s && !flush_i) begin
            nwr_s   = npush_s;
            nhead_s = npop_s;
        end else begin
            nwr_s   = 2'd0;
            nhead_s = flush_i ? 2'd0 : npop_s;
        end
        if (byp_s && (npop_s == 2'd1)) begin
            wr_data0_s = in_e1_s;
        end else begin
            wr_data0_s = push0_s;
        end
    end

    // Queue pointers and occupancy; flush empties the queue next cycle
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
        end else if (flush_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
        end else begin
            head_r  <= head_r + PTR_W'(nhead_s);
            tail_r  <= tail_r + PTR_W'(nwr_s);
            count_r <= count_r + (PTR_W+1)'(nwr_s) - (PTR_W+1)'(nhead_s);
        end
    end

    iq_entry_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .wr_en0   (nwr_s != 2'd0),
        .wr_addr0 (tail_r),
        .wr_data0 (wr_data0_s),
        .wr_en1   (nwr_s == 2'd2),
        .wr_addr1 (tail_r + PTR_W'(1)),
        .wr_data1 (in_e1_s),
        .rd_addr0 (head_r),
        .rd_data0 (rd0_s),
        .rd_addr1 (head_r + PTR_W'(1)),
        .rd_data1 (rd1_s)
    );

    inst_queue_chk u_chk (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .in_valid0_i (in_valid0_i),
        .in_valid1_i (in_valid1_i)
    );

    // Issue-side view: stored head pair, or the incoming pair when bypassing;
    // invalid slots are replaced by a harmless NOP
    always_comb begin
        if (byp_s) begin
            view0_s = push0_s;
            view1_s = in_e1_s;
            vld0_s  = (npush_s != 2'd0);
            vld1_s  = (npush_s == 2'd2);
        end else begin
            view0_s = rd0_s;
            view1_s = rd1_s;
            vld0_s  = (count_r >= CNT_ONE);
            vld1_s  = (count_r >= CNT_TWO);
        end
        out0_s = vld0_s ? view0_s : nop_entry();
        out1_s = vld1_s ? view1_s : nop_entry();
    end

    assign in_ready_o   = ready_s;
    assign out_valid0_o = vld0_s;
    assign out_valid1_o = vld1_s;
    assign inst0_o      = out0_s.inst;
    assign inst1_o      = out1_s.inst;
    assign ctrl0_o      = out0_s.ctrl;
    assign ctrl1_o      = out1_s.ctrl;
    assign pred_0_o     = out0_s.pred;
    assign pred_1_o     = out1_s.pred;
    assign pred_tgt_0_o = out0_s.pred_tgt;
    assign pred_tgt_1_o = out1_s.pred_tgt;
    assign pc_0_o       = out0_s.pc;
    assign pc_1_o       = out1_s.pc;
    assign count_o      = count_r;

endmodule

// File: tb/tb_inst_queue.sv
`timescale 1ns/1ps
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic              clock_i = 1'b0;
    logic              reset_i, flush_i, in_valid0_i, in_valid1_i;
    logic [31:0]       in_inst0_i, in_inst1_i, in_pred_tgt0_i, in_pred_tgt1_i, in_pc0_i, in_pc1_i;
    logic [CTRL_W-1:0] in_ctrl0_i, in_ctrl1_i, ctrl0_o, ctrl1_o;
    logic              in_pred0_i, in_pred1_i, in_ready_o;
    logic              stall_i, issue0_special_stall_i, issue1_special_stall_i;
    logic              out_valid0_o, out_valid1_o, pred_0_o, pred_1_o;
    logic [31:0]       inst0_o, inst1_o, pred_tgt_0_o, pred_tgt_1_o, pc_0_o, pc_1_o;
    logic [PTR_W:0]    count_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_pc [$];

    always #5 clock_i = ~clock_i;

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid0_i(in_valid0_i), .in_valid1_i(in_valid1_i),
        .in_inst0_i(in_inst0_i), .in_inst1_i(in_inst1_i),
        .in_ctrl0_i(in_ctrl0_i), .in_ctrl1_i(in_ctrl1_i),
        .in_pred0_i(in_pred0_i), .in_pred1_i(in_pred1_i),
        .in_pred_tgt0_i(in_pred_tgt0_i), .in_pred_tgt1_i(in_pred_tgt1_i),
        .in_pc0_i(in_pc0_i), .in_pc1_i(in_pc1_i),
        .in_ready_o(in_ready_o), .stall_i(stall_i),
        .issue0_special_stall_i(issue0_special_stall_i),
        .issue1_special_stall_i(issue1_special_stall_i),
        .out_valid0_o(out_valid0_o), .out_valid1_o(out_valid1_o),
        .inst0_o(inst0_o), .inst1_o(inst1_o),
        .ctrl0_o(ctrl0_o), .ctrl1_o(ctrl1_o),
        .pred_0_o(pred_0_o), .pred_1_o(pred_1_o),
        .pred_tgt_0_o(pred_tgt_0_o), .pred_tgt_1_o(pred_tgt_1_o),
        .pc_0_o(pc_0_o), .pc_1_o(pc_1_o), .count_o(count_o)
    );

    // Payload fields derived from the PC so a scoreboard of PCs suffices
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction
    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] pc);
        return CTRL_W'(pc ^ 32'h0000_5A5A);
    endfunction
    function automatic logic [31:0] tgt_of(input logic [31:0] pc);
        return pc + 32'h0000_0100;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit v1, input logic [31:0] p0, input logic [31:0] p1,
                         input bit st, input bit s0, input bit s1, input bit fl);
        in_valid0_i = v0;          in_valid1_i = v1;
        in_pc0_i = p0;             in_pc1_i = p1;
        in_inst0_i = inst_of(p0);  in_inst1_i = inst_of(p1);
        in_ctrl0_i = ctrl_of(p0);  in_ctrl1_i = ctrl_of(p1);
        in_pred0_i = p0[2];        in_pred1_i = p1[2];
        in_pred_tgt0_i = tgt_of(p0); in_pred_tgt1_i = tgt_of(p1);
        stall_i = st; issue0_special_stall_i = s0; issue1_special_stall_i = s1; flush_i = fl;
    endtask

    // Compare the registered queue view against the scoreboard contents
    task automatic check_view(input string tag);
        int n;
        logic [31:0] e_pc0, e_pc1, e_i0, e_i1;
        logic [CTRL_W-1:0] e_c0;
        logic [31:0] e_t0;
        n = sb_pc.size();
        e_pc0 = 32'h0; e_pc1 = 32'h0; e_i0 = NOP_INST; e_i1 = NOP_INST;
        e_c0 = {CTRL_W{1'b0}}; e_t0 = 32'h0;
        if (n >= 1) begin
            e_pc0 = sb_pc[0]; e_i0 = inst_of(sb_pc[0]);
            e_c0 = ctrl_of(sb_pc[0]); e_t0 = tgt_of(sb_pc[0]);
        end
        if (n >= 2) begin
            e_pc1 = sb_pc[1]; e_i1 = inst_of(sb_pc[1]);
        end
        chk({tag, ".count"}, 64'(count_o), 64'(n));
        chk({tag, ".ready"}, 64'(in_ready_o), 64'((DEPTH - n) >= 2));
        chk({tag, ".v0"}, 64'(out_valid0_o), 64'(n >= 1));
        chk({tag, ".v1"}, 64'(out_valid1_o), 64'(n >= 2));
        chk({tag, ".pc0"}, 64'(pc_0_o), 64'(e_pc0));
        chk({tag, ".pc1"}, 64'(pc_1_o), 64'(e_pc1));
        chk({tag, ".inst0"}, 64'(inst0_o), 64'(e_i0));
        chk({tag, ".inst1"}, 64'(inst1_o), 64'(e_i1));
        chk({tag, ".ctrl0"}, 64'(ctrl0_o), 64'(e_c0));
        chk({tag, ".tgt0"}, 64'(pred_tgt_0_o), 64'(e_t0));
    endtask

    // Drive one cycle, update the scoreboard, clock, then check the view
    task automatic cyc(input string tag, input bit v0, input bit v1,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input bit st, input bit s0, input bit s1, input bit fl);
        int n, np, npop, avail;
        bit byp;
        drive(v0, v1, p0, p1, st, s0, s1, fl);
        n = sb_pc.size();
        if (fl) begin
            sb_pc.delete();
        end else begin
            np = int'(v0) + int'(v1);
            byp = 1'b0;
`ifdef IQ_BYPASS_EN
            byp = (n == 0);
`endif
            avail = byp ? np : n;
            if (st || s0) npop = 0;
            else if (s1) npop = (avail >= 1) ? 1 : 0;
            else npop = (avail >= 2) ? 2 : avail;
            if (byp) begin
                if (v0) sb_pc.push_back(p0);
                if (v1) sb_pc.push_back(p1);
                for (int i = 0; i < npop; i++) void'(sb_pc.pop_front());
            end else begin
                for (int i = 0; i < npop; i++) void'(sb_pc.pop_front());
                if ((DEPTH - n) >= 2) begin
                    if (v0) sb_pc.push_back(p0);
                    if (v1) sb_pc.push_back(p1);
                end
            end
        end
        @(posedge clock_i);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_view(tag);
    endtask

    initial begin
        reset_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check_view("reset");
        reset_i = 1'b0;

        // Basic pair, then drain with no stalls
        cyc("pair",  1, 1, 32'h0, 32'h4, 0, 0, 0, 0);
        cyc("drain", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

        // Slot-1 hold retires only slot 0; slot 1 moves up
        cyc("pair2",  1, 1, 32'h0, 32'h4, 1, 0, 0, 0);
        cyc("s1hold", 0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
        cyc("s0hold", 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
        cyc("drain2", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

        // Fill to full under global stall; extra push is refused
        for (int k = 0; k < 4; k++)
            cyc("fill", 1, 1, 32'(k * 8), 32'(k * 8 + 4), 1, 0, 0, 0);
        cyc("full_push", 1, 1, 32'h20, 32'h24, 1, 0, 0, 0);
        cyc("full_pop",  1, 1, 32'h20, 32'h24, 0, 0, 0, 0);
        cyc("pushpop",   1, 1, 32'h28, 32'h2C, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            cyc("wrapdrain", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

        // Build count 5 (pairs + single), then flush with a push
        cyc("f_a", 1, 1, 32'h200, 32'h204, 1, 0, 0, 0);
        cyc("f_b", 1, 1, 32'h208, 32'h20C, 1, 0, 0, 0);
        cyc("f_c", 1, 0, 32'h210, 32'h0,   1, 0, 0, 0);
        cyc("flush", 1, 1, 32'h300, 32'h304, 0, 0, 0, 1);
        cyc("empty_stall", 0, 0, 32'h0, 32'h0, 0, 0, 1, 0);

        // Asynchronous reset mid-cycle with three entries
        cyc("r_a", 1, 1, 32'h400, 32'h404, 1, 0, 0, 0);
        cyc("r_b", 1, 0, 32'h408, 32'h0,   1, 0, 0, 0);
        #3 reset_i = 1'b1;
        sb_pc.delete();
        #1;
        check_view("async_rst");
        #2 reset_i = 1'b0;
        cyc("post_rst", 1, 1, 32'h500, 32'h504, 1, 0, 0, 0);
        cyc("post_rst_drain", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

`ifdef IQ_BYPASS_EN
        // Same-cycle forwarding from an empty queue
        drive(1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("byp.pc0", 64'(pc_0_o), 64'(32'h100));
        chk("byp.pc1", 64'(pc_1_o), 64'(32'h104));
        chk("byp.v1", 64'(out_valid1_o), 64'(1));
        chk("byp.count", 64'(count_o), 64'(0));
        cyc("byp_pop2", 1, 1, 32'h100, 32'h104, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("byp_s1.pc0", 64'(pc_0_o), 64'(32'h100));
        cyc("byp_s1", 1, 1, 32'h100, 32'h104, 0, 0, 1, 0);
        chk("byp_s1.next_pc0", 64'(pc_0_o), 64'(32'h104));
        cyc("byp_drain", 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Dual-entry-per-cycle instruction queue that feeds the issue stage's instruction pair (inst0/inst1, ctrl, prediction, PC). It accepts up to two decoded instructions per cycle from decode and presents the two oldest entries to issue. Entries are retired according to issue's stall feedback: both slots, slot 0 only (slot-1 special stall), or none. Slot 1 is never lost when slot 1 stalls: that instruction becomes slot 0 on the next cycle.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), width of the head/tail pointers; the occupancy count is PTR_W+1 bits.

Ports:
- clock_i  in  1  core clock
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  mispredict/redirect; discard all entries
- in_valid0_i  in  1  decode slot 0 valid (older)
- in_valid1_i  in  1  decode slot 1 valid; legal only with in_valid0_i
- in_inst0_i / in_inst1_i  in  32  instruction words
- in_ctrl0_i / in_ctrl1_i  in  `CTRL_BUS  decoded control
- in_pred0_i / in_pred1_i  in  1  predicted-taken flags
- in_pred_tgt0_i / in_pred_tgt1_i  in  32  predicted targets
- in_pc0_i / in_pc1_i  in  32  PCs
- in_ready_o  out  1  queue can accept a full pair this cycle
- stall_i  in  1  global pipeline stall (no retire)
- issue0_special_stall_i  in  1  slot-0 hold (no retire)
- issue1_special_stall_i  in  1  slot-1 hold (retire slot 0 only)
- out_valid0_o / out_valid1_o  out  1  head / head+1 entry valid
- inst0_o / inst1_o  out  32  oldest and next-oldest instruction
- ctrl0_o / ctrl1_o  out  `CTRL_BUS
- pred_0_o / pred_1_o  out  1
- pred_tgt_0_o / pred_tgt_1_o  out  32
- pc_0_o / pc_1_o  out  32
- count_o  out  PTR_W+1  current occupancy

Behaviour:
- Storage: circular buffer with head, tail and count registers. An entry is {inst, ctrl, pred, pred_tgt, pc}.
- Reset (async): head=0, tail=0, count=0, in_ready_o=1, out_valid*=0. Reset mid-operation drops all entries immediately.
- in_ready_o = (DEPTH - count) >= 2. It is computed from the current count only; same-cycle pops are not credited.
- Push, when in_ready_o=1:
  - npush = in_valid0_i + in_valid1_i.
  - Slot 0 is written at tail, slot 1 at tail+1.
  - tail advances by npush modulo DEPTH.
  - Inputs are ignored when in_ready_o=0; decode must hold them.
- Output view:
  - out_valid0_o = count>=1; out_valid1_o = count>=2.
  - Slot 0 = entry[head]; slot 1 = entry[head+1] (wraps).
  - An invalid slot drives inst=32'h00000013 (NOP), ctrl=0, pred=0, pred_tgt=0, pc=0, so REGWRITE=0 and issue sees no dependency.
- Pop, evaluated in priority order:
  1. stall_i or issue0_special_stall_i → npop=0.
  2. Otherwise issue1_special_stall_i → npop = min(1, count).
  3. Otherwise npop = min(2, count).
  - head advances by npop.
- Simultaneous push and pop: count' = count + npush − npop. Both pointers wrap independently.
- flush_i has priority over push and pop in the same cycle. Next cycle: head=tail=count=0. Pushes in the flush cycle are discarded.
- Push-to-visible latency is 1 cycle (written entries appear at the outputs next cycle).
- Ordering is strictly FIFO; slot 0 is always the older instruction.
- in_valid1_i without in_valid0_i is illegal: assert in simulation. In RTL the entry is treated as a slot-0 push.
- Full: count=DEPTH-1 gives in_ready_o=0; the queue never overflows.
- Empty: both outputs are NOPs; stall inputs have no effect.

Optional Feature:
IQ_BYPASS_EN
- Defined:
  - When count==0 and flush_i=0, the incoming pair drives the outputs combinationally in the same cycle, with out_valid* = in_valid*.
  - npop is computed on these bypassed slots; only un-popped instructions are written, starting at tail.
  - Empty-queue latency becomes 0 cycles.
- Undefined: there is no bypass path and latency is always 1 cycle.

Decomposition:
- Shared package/defs:
  - NOP_INST (32'h00000013)
  - IQ entry field layout and entry width constant (32+CTRL+1+32+32)
  - IQ_DEPTH default
- Sub-module iq_entry_mem: DEPTH×entry-width array with 2 write ports (tail, tail+1) and 2 combinational read ports (head, head+1).
- inst_queue holds the pointers, count, pop/push arithmetic, NOP muxing and the bypass.

Test Plan:
- Reset, then push pair PC 0x0/0x4 → next cycle out_valid0/1=1, pc_0_o=0x0, pc_1_o=0x4, count_o=2; with no stalls, count_o=0 the following cycle.
- 2 entries (0x0, 0x4) with issue1_special_stall_i=1 for one cycle → next cycle pc_0_o=0x4, out_valid1_o=0 (or 0x8 if pushed); count_o drops by exactly 1.
- DEPTH=8: push 4 pairs with stall_i=1 → in_ready_o=0 at count=8; a further push is ignored; release stall → FIFO order 0x0…0x1C; pointers wrap on refill.
- count=5, flush_i asserted together with a valid push → next cycle count_o=0, out_valid*=0, inst0_o=32'h00000013; the push is lost.
- Assert reset_i asynchronously mid-cycle with count=3 → outputs invalid immediately, in_ready_o=1.
- IQ_BYPASS_EN: empty queue, push pair 0x100/0x104 with no stall → pc_0_o=0x100 in the same cycle and count stays 0; same stimulus with issue1_special_stall_i=1 → count_o=1 and next pc_0_o=0x104.
